// File: rtl/uart_word_packer.sv
// Packs UART bytes big-endian into FIFO_WR_BYTE-byte words, counts frames and drops.
// Optional macro PACK_TIMEOUT_EN adds an idle-gap resync of the partial word and frame count.
module uart_word_packer #(
  parameter int FIFO_WR_BYTE  = 4,
  parameter int FIFO_WR_WIDTH = 32,
  parameter int FRAME_WORDS   = 1228800,
  parameter int TIMEOUT_CYC   = 2000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               byte_data,
  input  logic                     byte_valid,
  input  logic                     wr_full,
  output logic [FIFO_WR_WIDTH-1:0] fifo_wr_data,
  output logic                     fifo_wr_en,
  output logic                     frame_done,
  output logic [15:0]              drop_cnt,
  output logic                     timeout_pulse
);

  localparam int IDX_W  = (FIFO_WR_BYTE > 1) ? $clog2(FIFO_WR_BYTE) : 1;
  localparam int WCNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FIFO_WR_BYTE - 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(FRAME_WORDS - 1);

  typedef enum logic {ST_EMPTY, ST_FILL} state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [IDX_W-1:0]         r_byte_idx;
  logic [IDX_W-1:0]         w_idx_cur;
  logic [WCNT_W-1:0]        r_word_cnt;
  logic [WCNT_W-1:0]        w_word_cnt_cur;
  logic [FIFO_WR_WIDTH-1:0] r_word;
  logic [FIFO_WR_WIDTH-1:0] w_word_merged;
  logic [FIFO_WR_WIDTH-1:0] r_fifo_wr_data;
  logic                     r_fifo_wr_en;
  logic                     r_frame_done;
  logic [15:0]              r_drop_cnt;
  logic                     w_timeout;
  logic                     w_last_byte;

`ifdef PACK_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYC);
  localparam logic [IDLE_W-1:0] IDLE_FIRE = IDLE_W'(TIMEOUT_CYC - 1);

  logic [IDLE_W-1:0] r_idle_cnt;
  logic              r_timeout_pulse;

  // Counts consecutive cycles without a byte; parks at TIMEOUT_CYC so each gap fires once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle_cnt <= '0;
    end else if (byte_valid) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt != IDLE_MAX) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_idle_cnt == IDLE_FIRE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout_pulse <= 1'b0;
    end else begin
      r_timeout_pulse <= w_timeout;
    end
  end

  assign timeout_pulse = r_timeout_pulse;
`else
  assign w_timeout     = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  // A resync in this cycle takes effect before any byte arriving in the same cycle.
  assign w_idx_cur      = w_timeout ? '0 : r_byte_idx;
  assign w_word_cnt_cur = w_timeout ? '0 : r_word_cnt;
  assign w_last_byte    = (w_idx_cur == LAST_IDX);

  generate
    for (genvar gi = 0; gi < FIFO_WR_BYTE; gi++) begin : g_lane
      localparam int LSB = (FIFO_WR_BYTE - 1 - gi) * 8;
      assign w_word_merged[LSB +: 8] =
        (byte_valid && (w_idx_cur == IDX_W'(gi))) ? byte_data : r_word[LSB +: 8];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    if (w_timeout) begin
      w_state_next = ST_EMPTY;
    end
    if (byte_valid) begin
      w_state_next = w_last_byte ? ST_EMPTY : ST_FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_EMPTY;
      r_byte_idx     <= '0;
      r_word_cnt     <= '0;
      r_word         <= '0;
      r_fifo_wr_data <= '0;
      r_fifo_wr_en   <= 1'b0;
      r_frame_done   <= 1'b0;
      r_drop_cnt     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_byte_idx   <= w_idx_cur;
      r_word_cnt   <= w_word_cnt_cur;
      r_fifo_wr_en <= 1'b0;
      r_frame_done <= 1'b0;
      if (byte_valid) begin
        r_word     <= w_word_merged;
        r_byte_idx <= w_last_byte ? '0 : w_idx_cur + 1'b1;
        if (w_last_byte) begin
          r_frame_done <= (w_word_cnt_cur == LAST_WORD);
          r_word_cnt   <= (w_word_cnt_cur == LAST_WORD) ? '0 : w_word_cnt_cur + 1'b1;
          if (wr_full) begin
            if (r_drop_cnt != 16'hFFFF) begin
              r_drop_cnt <= r_drop_cnt + 16'd1;
            end
          end else begin
            r_fifo_wr_en   <= 1'b1;
            r_fifo_wr_data <= w_word_merged;
          end
        end
      end
    end
  end

  assign fifo_wr_data = r_fifo_wr_data;
  assign fifo_wr_en   = r_fifo_wr_en;
  assign frame_done   = r_frame_done;
  assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_uart_word_packer.sv
// Directed and random stimulus for uart_word_packer, checked every cycle against a byte-queue model.
// Build with PACK_TIMEOUT_EN defined to exercise the idle-gap resync.
module tb_uart_word_packer;

  localparam int NB    = 4;
  localparam int WW    = 32;
  localparam int FW    = 4;
  localparam int TO    = 10;

  logic          clk;
  logic          rst;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          wr_full;
  logic [WW-1:0] fifo_wr_data;
  logic          fifo_wr_en;
  logic          frame_done;
  logic [15:0]   drop_cnt;
  logic          timeout_pulse;

  uart_word_packer #(
    .FIFO_WR_BYTE (NB),
    .FIFO_WR_WIDTH(WW),
    .FRAME_WORDS  (FW),
    .TIMEOUT_CYC  (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .wr_full      (wr_full),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_en   (fifo_wr_en),
    .frame_done   (frame_done),
    .drop_cnt     (drop_cnt),
    .timeout_pulse(timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bytes of the open word, frame word count, drops, idle gap length.
  byte unsigned  q_bytes[$];
  int            m_wcnt;
  int            m_drop;
  int            m_gap;
  logic [WW-1:0] e_data;
  logic          e_en;
  logic          e_fd;
  logic          e_to;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic v, input logic [7:0] d, input logic f);
    logic [WW-1:0] word;
    e_en = 1'b0;
    e_fd = 1'b0;
    e_to = 1'b0;
    if (r) begin
      q_bytes.delete();
      m_wcnt = 0;
      m_drop = 0;
      m_gap  = 0;
      e_data = '0;
    end else begin
`ifdef PACK_TIMEOUT_EN
      if (m_gap == TO - 1) begin
        e_to = 1'b1;
        q_bytes.delete();
        m_wcnt = 0;
      end
`endif
      m_gap = v ? 0 : m_gap + 1;
      if (v) begin
        q_bytes.push_back(d);
        if (q_bytes.size() == NB) begin
          word = '0;
          foreach (q_bytes[i]) word = (word << 8) | WW'(q_bytes[i]);
          q_bytes.delete();
          if (f) begin
            m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
          end else begin
            e_en   = 1'b1;
            e_data = word;
          end
          e_fd   = (m_wcnt == FW - 1);
          m_wcnt = (m_wcnt + 1) % FW;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic f);
    rst        = r;
    byte_valid = v;
    byte_data  = d;
    wr_full    = f;
    @(posedge clk);
    model_update(r, v, d, f);
    #1;
    chk("model_wr_en",   64'(fifo_wr_en),    64'(e_en));
    chk("model_wr_data", 64'(fifo_wr_data),  64'(e_data));
    chk("model_frame",   64'(frame_done),    64'(e_fd));
    chk("model_drop",    64'(drop_cnt),      64'(m_drop));
    chk("model_timeout", 64'(timeout_pulse), 64'(e_to));
  endtask

  task automatic send(input logic [7:0] d, input logic f);
    step(1'b0, 1'b1, d, f);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  int pulses;

  initial begin
    rst = 1'b1; byte_valid = 1'b0; byte_data = '0; wr_full = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("reset_data", 64'(fifo_wr_data), 64'h0);
    chk("reset_en",   64'(fifo_wr_en),   64'h0);
    chk("reset_drop", 64'(drop_cnt),     64'h0);
    $display("reset done");

    // Single word, big-endian
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    chk("word_en",   64'(fifo_wr_en),   64'h1);
    chk("word_data", 64'(fifo_wr_data), 64'h11223344);
    $display("word 11223344: en=%0b data=%h", fifo_wr_en, fifo_wr_data);

    // Back-to-back bytes, two words
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), 1'b0);
      if (i == 4) chk("b2b_word1", 64'(fifo_wr_data), 64'h01020304);
      if (i == 8) chk("b2b_word2", 64'(fifo_wr_data), 64'h05060708);
    end
    $display("back-to-back: last data=%h", fifo_wr_data);

    // Drop on full
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int w = 1; w <= 3; w++) begin
      for (int b = 0; b < NB; b++) send(8'((w << 4) | b), (w == 2) && (b == NB - 1));
      if (w == 2) begin
        chk("drop_no_en", 64'(fifo_wr_en), 64'h0);
        chk("drop_cnt1",  64'(drop_cnt),   64'h1);
      end
      if (w == 3) chk("drop_next_data", 64'(fifo_wr_data), 64'h30313233);
    end
    $display("drop: drop_cnt=%0d data=%h", drop_cnt, fifo_wr_data);

    // Frame boundary at every FW words
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      send(8'(i), 1'b0);
      if (i == 12) chk("frame_mid", 64'(frame_done), 64'h0);
      if (i == 16) chk("frame_w4",  64'(frame_done), 64'h1);
      if (i == 20) chk("frame_w5",  64'(frame_done), 64'h0);
      if (i == 32) chk("frame_w8",  64'(frame_done), 64'h1);
    end
    $display("frame: frame_done=%0b at word 8", frame_done);

    // Idle gap after a partial word
    step(1'b1, 1'b0, 8'h00, 1'b0);
    send(8'hAA, 1'b0); send(8'hBB, 1'b0);
    pulses = 0;
    for (int i = 0; i < TO + 2; i++) begin
      idle(1);
      pulses += int'(timeout_pulse);
    end
    send(8'h01, 1'b0); send(8'h02, 1'b0);
`ifdef PACK_TIMEOUT_EN
    chk("gap_pulses", 64'(pulses), 64'd1);
    send(8'h03, 1'b0); send(8'h04, 1'b0);
    chk("gap_data", 64'(fifo_wr_data), 64'h01020304);
`else
    chk("gap_pulses", 64'(pulses), 64'd0);
    chk("gap_data", 64'(fifo_wr_data), 64'hAABB0102);
`endif
    $display("gap: pulses=%0d data=%h", pulses, fifo_wr_data);

    // Reset mid-word, bytes during reset ignored
    step(1'b1, 1'b0, 8'h00, 1'b0);
    send(8'hE1, 1'b0); send(8'hE2, 1'b0);
    step(1'b1, 1'b1, 8'h99, 1'b0);
    step(1'b1, 1'b1, 8'h98, 1'b0);
    chk("rst_mid_data", 64'(fifo_wr_data), 64'h0);
    chk("rst_mid_en",   64'(fifo_wr_en),   64'h0);
    chk("rst_mid_fd",   64'(frame_done),   64'h0);
    send(8'hC1, 1'b0); send(8'hC2, 1'b0); send(8'hC3, 1'b0);
    chk("rst_mid_no_early", 64'(fifo_wr_en), 64'h0);
    send(8'hC4, 1'b0);
    chk("rst_mid_word", 64'(fifo_wr_data), 64'hC1C2C3C4);
    $display("reset mid-word: data=%h", fifo_wr_data);

    // Random traffic with occasional stalls, long gaps and resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        idle(int'($urandom_range(TO - 2, TO + 3)));
      end else begin
        step($urandom_range(0, 149) == 0, $urandom_range(0, 2) != 0,
             8'($urandom), $urandom_range(0, 3) == 0);
      end
    end
    $display("random: drop_cnt=%0d last data=%h", drop_cnt, fifo_wr_data);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
